// File: rtl/sched_pkg.sv
// Shared types and constants for the seat reset scheduler.
//   HOUR_W/MIN_W/TIME_W : widths of the {hour, min} time word used by the timer
//   MAX_HOUR            : largest legal programmable reset hour
//   sched_state_t       : sweep controller states
//   pack_time()         : builds the 11-bit {hour, min} time word
package sched_pkg;

  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned TIME_W = 11;

  localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } sched_state_t;

  function automatic logic [TIME_W-1:0] pack_time(input logic [HOUR_W-1:0] hour,
                                                  input logic [MIN_W-1:0]  min);
    return {hour, min};
  endfunction

endpackage

// File: rtl/seat_sweep_counter.sv
// Seat index counter for one sweep.
//   clk_i   : system clock
//   rst_i   : synchronous active-high reset, index to 0
//   start_i : sweep begins, index to 0
//   adv_i   : current index accepted (valid & ready), step to next seat
//   clr_i   : force index back to 0
//   idx_o   : current seat index
//   last_o  : index is the final seat (NUM_SEATS-1)
module seat_sweep_counter #(
  parameter int unsigned NUM_SEATS = 32,
  parameter int unsigned IDX_W     = $clog2(NUM_SEATS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             adv_i,
  input  logic             clr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o
);

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;

  // Compare against NUM_SEATS-1 so a non-power-of-2 seat count never emits
  // an out-of-range index.
  assign last_o = (idx_q == IDX_W'(NUM_SEATS - 1));
  assign idx_o  = idx_q;

  always_comb begin
    idx_d = idx_q;
    if (clr_i || start_i) begin
      idx_d = '0;
    end else if (adv_i) begin
      // Wrap on the final acceptance so the index is already 0 in DONE.
      idx_d = last_o ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/seat_reset_scheduler.sv
// Daily seat reset scheduler.
// Drives the hour/minute timer's compare value and, on a rising edge of its
// match flag or on a manual request, sweeps every seat issuing one clear
// command per seat over a valid/ready handshake.
//   clk, rst           : clock, synchronous active-high reset
//   cfg_valid/cfg_hour : offer a new reset hour; cfg_ready accepts, cfg_err
//                        pulses on an hour above 23
//   sweep_req          : manual sweep request pulse
//   time_in, rst_timer : current time and match flag from the timer
//   reset_time         : compare value {hour, 6'b0} to the timer
//   seat_clr_*         : clear command handshake to the seat-state store
//   sweep_busy/done    : sweep in progress / one-cycle completion pulse
//   last_sweep_time    : time_in captured when the last sweep started
module seat_reset_scheduler
  import sched_pkg::*;
#(
  parameter int unsigned NUM_SEATS    = 32,
  parameter int unsigned IDX_W        = $clog2(NUM_SEATS),
  parameter int unsigned DEFAULT_HOUR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  input  logic [HOUR_W-1:0] cfg_hour,
  output logic              cfg_ready,
  output logic              cfg_err,
  input  logic              sweep_req,
  input  logic [TIME_W-1:0] time_in,
  input  logic              rst_timer,
  output logic [TIME_W-1:0] reset_time,
  output logic              seat_clr_valid,
  output logic [IDX_W-1:0]  seat_clr_idx,
  input  logic              seat_clr_ready,
  output logic              sweep_busy,
  output logic              sweep_done,
  output logic [TIME_W-1:0] last_sweep_time
);

  sched_state_t      state_q;
  logic [HOUR_W-1:0] cfg_hour_q;
  logic              cfg_err_q;
  logic              rst_timer_q;
  logic [TIME_W-1:0] last_sweep_time_q;

  logic trig;
  logic clr_accept;
  logic idx_last;
  logic sweep_start;

  // Edge detect: a match already high at reset release is ignored because
  // rst_timer_q resets to 1.
  assign trig        = (rst_timer & ~rst_timer_q) | sweep_req;
  assign sweep_start = (state_q == IDLE) & trig;
  assign clr_accept  = seat_clr_valid & seat_clr_ready;

  assign cfg_ready       = (state_q == IDLE);
  assign seat_clr_valid  = (state_q == SWEEP);
  assign sweep_busy      = (state_q == SWEEP);
  assign sweep_done      = (state_q == DONE);
  assign cfg_err         = cfg_err_q;
  assign reset_time      = pack_time(cfg_hour_q, '0);
  assign last_sweep_time = last_sweep_time_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      cfg_hour_q        <= HOUR_W'(DEFAULT_HOUR);
      cfg_err_q         <= 1'b0;
      rst_timer_q       <= 1'b1;
      last_sweep_time_q <= '0;
    end else begin
      rst_timer_q <= rst_timer;
      cfg_err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // Config and trigger are independent; both may be taken together.
          if (cfg_valid) begin
            if (cfg_hour <= MAX_HOUR) begin
              cfg_hour_q <= cfg_hour;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
          if (trig) begin
            state_q           <= SWEEP;
            last_sweep_time_q <= time_in;
          end
        end
        SWEEP: begin
          // Triggers during a sweep are dropped, not queued.
          if (clr_accept && idx_last) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  seat_sweep_counter #(
    .NUM_SEATS (NUM_SEATS),
    .IDX_W     (IDX_W)
  ) u_counter (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (sweep_start),
    .adv_i   (clr_accept),
    .clr_i   (state_q == DONE),
    .idx_o   (seat_clr_idx),
    .last_o  (idx_last)
  );

endmodule

// File: doc/seat_reset_scheduler.md
Name: seat_reset_scheduler

Overview:
- Controller on the far side of the hour/minute timer: drives its reset_time compare value and consumes its rst_timer match flag.
- On a new match, or on a manual request, sweeps every seat slot and issues one clear command per seat to the seat-state store over a valid/ready handshake.
- Holds the programmable daily reset hour and records the timestamp of the last sweep.

Parameters:
- NUM_SEATS, 32, number of seat slots swept; must be ≥ 2.
- IDX_W, $clog2(NUM_SEATS), seat index width.
- DEFAULT_HOUR, 0, reset hour loaded at reset; range 0..23.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  new reset hour offered.
- cfg_hour  in  5  offered reset hour, 0..23.
- cfg_ready  out  1  config accepted this cycle when high with cfg_valid.
- cfg_err  out  1  one-cycle pulse: rejected hour (>23).
- sweep_req  in  1  manual sweep request, single-cycle pulse.
- time_in  in  11  current time from the timer: {hour[4:0], min[5:0]}.
- rst_timer  in  1  timer match flag; level, high while the hour matches.
- reset_time  out  11  compare value to the timer: {cfg_hour_q, 6'b0}.
- seat_clr_valid  out  1  clear command valid.
- seat_clr_idx  out  IDX_W  seat index to clear.
- seat_clr_ready  in  1  store accepts the command.
- sweep_busy  out  1  high while a sweep is in progress.
- sweep_done  out  1  one-cycle pulse after the last seat is accepted.
- last_sweep_time  out  11  time_in captured at sweep start.

Behaviour:
- Reset values: cfg_hour_q=DEFAULT_HOUR, so reset_time={DEFAULT_HOUR,6'b0}. seat_clr_valid=0, seat_clr_idx=0, sweep_busy=0, sweep_done=0, cfg_err=0, last_sweep_time=0, state=IDLE, rst_timer_q=1.
- rst_timer_q resets to 1 so that a match already active when reset deasserts does not start a sweep.
- Trigger: trig = (rst_timer & ~rst_timer_q) | sweep_req. rst_timer_q is a one-register copy of rst_timer.
- State IDLE:
  - cfg_ready=1.
  - On cfg_valid with cfg_hour≤23: cfg_hour_q is updated next cycle.
  - On cfg_valid with cfg_hour>23: cfg_err pulses next cycle and cfg_hour_q is unchanged.
  - On trig: go to SWEEP next cycle and capture last_sweep_time=time_in at the trigger cycle.
- trig and cfg_valid in the same IDLE cycle: both are taken. The config write does not cancel the sweep.
- State SWEEP:
  - cfg_ready=0, sweep_busy=1, seat_clr_valid=1.
  - seat_clr_idx starts at 0 and increments only on seat_clr_valid & seat_clr_ready.
  - seat_clr_idx holds stable while ready is low.
  - Acceptance at idx=NUM_SEATS-1 moves to DONE. seat_clr_valid deasserts the next cycle; no extra command is issued.
  - Any trig during SWEEP is ignored and not queued.
- State DONE: lasts one cycle. sweep_done=1, sweep_busy=0, seat_clr_idx returns to 0. Next state is IDLE.
- Latency: trig at cycle T gives seat_clr_valid high at T+1. With ready held high, the minimum sweep is NUM_SEATS cycles and sweep_done is at T+NUM_SEATS+1.
- Re-arm: rst_timer stays high for the whole matching hour, but the edge detect gives only one sweep per rising edge. The next automatic sweep requires rst_timer to fall and rise again.
- rst asserted mid-sweep: the sweep is aborted at the next edge. All outputs return to reset values, no sweep_done pulse, no partial resumption.
- Index arithmetic is IDX_W-bit. Terminal compare uses NUM_SEATS-1, so non-power-of-2 NUM_SEATS never emits an out-of-range index.

Decomposition:
- Package sched_pkg:
  - HOUR_W=5, MIN_W=6, TIME_W=11, MAX_HOUR=5'd23.
  - enum sched_state_t {IDLE, SWEEP, DONE}.
  - Helper function for packing {hour, min} into the 11-bit time word.
- One sub-module, seat_sweep_counter: NUM_SEATS-parameterised index counter with start, advance (valid&ready), last and clear signals. The top level holds the FSM, config register and edge detect.

Test Plan:
- Reset release with rst_timer already 1 → no seat_clr_valid for 10 cycles. reset_time=11'h000 when DEFAULT_HOUR=0.
- cfg_valid, cfg_hour=7 in IDLE → reset_time=11'h1C0 next cycle. Then cfg_hour=24 → cfg_err one pulse, reset_time stays 11'h1C0.
- rst_timer 0→1 with time_in={7,0}, seat_clr_ready=1, NUM_SEATS=32 → idx 0..31 on consecutive cycles. sweep_done exactly 33 cycles after the trigger. last_sweep_time=11'h1C0. rst_timer held high 100 cycles → no second sweep.
- Sweep with seat_clr_ready toggling 1,0,0,1… → each index 0..31 accepted exactly once, in order. idx stable while ready=0. A sweep_req mid-sweep produces no extra commands.
- rst asserted while idx=12 → next cycle seat_clr_valid=0, idx=0, sweep_busy=0, no sweep_done. A following sweep_req restarts from idx 0.
- Same-cycle sweep_req and cfg_valid (hour 3) in IDLE → sweep starts and reset_time=11'h0C0.
